// File: rtl/spi_pwm_frame_rx.sv
// SPI receiver for checksummed PWM configuration frames (LSB-first, spi_sclk domain).
// Commits divider/duty only on a full-length frame with a matching XOR checksum.
module spi_pwm_frame_rx #(
  parameter int unsigned CLOCK_DIV_WIDTH   = 32,
  parameter int unsigned DUTY_CYCLE_WIDTH  = 8,
  parameter int unsigned DEFAULT_CLOCK_DIV = 17,
  parameter int unsigned DEFAULT_DUTY      = 0
) (
  input  logic                        rst,
  input  logic                        spi_sclk,
  input  logic                        spi_cs,
  input  logic                        spi_mosi,
  output logic                        spi_miso,
  output logic [CLOCK_DIV_WIDTH-1:0]  cfg_div,
  output logic [DUTY_CYCLE_WIDTH-1:0] cfg_duty,
  output logic                        cfg_toggle,
  output logic                        frame_ok,
  output logic                        frame_err,
  output logic [3:0]                  err_count
);

  localparam int P     = CLOCK_DIV_WIDTH + DUTY_CYCLE_WIDTH;
  localparam int F     = P + 8;
  localparam int CNT_W = $clog2(F + 1);

  localparam logic [CNT_W-1:0] PAY_END  = CNT_W'(P);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(F - 1);
  localparam logic [CNT_W-1:0] DONE_CNT = CNT_W'(F);
  localparam logic [CNT_W-1:0] STAT_LEN = CNT_W'(8);

  typedef enum logic [1:0] {IDLE, SHIFT, HOLD} state_t;

  state_t            state;
  logic [P-1:0]      payload;
  logic [7:0]        acc;
  logic [7:0]        chk;
  logic [7:0]        snap;
  logic [CNT_W-1:0]  bit_count;
  logic              ok_flag;
  logic              chk_err;
  logic              len_err;
  logic              overrun_seen;
  logic [7:0]        status_live;
  logic [7:0]        rx_chk;

  assign status_live = {err_count, 1'b0, len_err, chk_err, ok_flag};
  // Checksum byte as it stands once the incoming bit is included.
  assign rx_chk      = {spi_mosi, chk[7:1]};

  // Bit 0 comes from live status before the first edge; later bits from the snapshot.
  assign spi_miso = (!spi_cs && (bit_count < STAT_LEN))
                    ? ((bit_count == '0) ? status_live[0] : snap[bit_count[2:0]])
                    : 1'b0;

  function automatic logic [3:0] sat_inc(input logic [3:0] v);
    return (v == 4'hF) ? v : v + 4'd1;
  endfunction

  always_ff @(posedge spi_sclk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      payload      <= '0;
      acc          <= '0;
      chk          <= '0;
      snap         <= '0;
      bit_count    <= '0;
      ok_flag      <= 1'b0;
      chk_err      <= 1'b0;
      len_err      <= 1'b0;
      overrun_seen <= 1'b0;
      cfg_div      <= CLOCK_DIV_WIDTH'(DEFAULT_CLOCK_DIV);
      cfg_duty     <= DUTY_CYCLE_WIDTH'(DEFAULT_DUTY);
      cfg_toggle   <= 1'b0;
      frame_ok     <= 1'b0;
      frame_err    <= 1'b0;
      err_count    <= '0;
    end else begin
      frame_ok  <= 1'b0;
      frame_err <= 1'b0;
      case (state)
        IDLE: begin
          if (!spi_cs) begin
            payload   <= {spi_mosi, payload[P-1:1]};
            acc       <= {7'b0, spi_mosi};
            bit_count <= CNT_W'(1);
            snap      <= status_live;
            state     <= SHIFT;
          end
        end
        SHIFT: begin
          if (spi_cs) begin
            state     <= IDLE;
            bit_count <= '0;
            ok_flag   <= 1'b0;
            chk_err   <= 1'b0;
            len_err   <= 1'b1;
            frame_err <= 1'b1;
            err_count <= sat_inc(err_count);
          end else begin
            if (bit_count < PAY_END) begin
              payload                <= {spi_mosi, payload[P-1:1]};
              acc[bit_count[2:0]]    <= acc[bit_count[2:0]] ^ spi_mosi;
            end else begin
              chk <= rx_chk;
            end
            if (bit_count == LAST_BIT) begin
              state        <= HOLD;
              bit_count    <= DONE_CNT;
              overrun_seen <= 1'b0;
              len_err      <= 1'b0;
              if (rx_chk == acc) begin
                cfg_div    <= payload[CLOCK_DIV_WIDTH-1:0];
                cfg_duty   <= payload[P-1:CLOCK_DIV_WIDTH];
                cfg_toggle <= ~cfg_toggle;
                frame_ok   <= 1'b1;
                ok_flag    <= 1'b1;
                chk_err    <= 1'b0;
              end else begin
                ok_flag    <= 1'b0;
                chk_err    <= 1'b1;
                frame_err  <= 1'b1;
                err_count  <= sat_inc(err_count);
              end
            end else begin
              bit_count <= bit_count + 1'b1;
            end
          end
        end
        HOLD: begin
          if (spi_cs) begin
            state     <= IDLE;
            bit_count <= '0;
          end else if (!overrun_seen) begin
            overrun_seen <= 1'b1;
            ok_flag      <= 1'b0;
            chk_err      <= 1'b0;
            len_err      <= 1'b1;
            frame_err    <= 1'b1;
            err_count    <= sat_inc(err_count);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_pwm_frame_rx.sv
// Directed bench for spi_pwm_frame_rx: table of whole frames plus hand-written
// abort, overrun, saturation, mid-frame reset and status readback sequences.
module tb_spi_pwm_frame_rx;

  logic        rst;
  logic        spi_sclk;
  logic        spi_cs;
  logic        spi_mosi;
  logic        spi_miso;
  logic [31:0] cfg_div;
  logic [7:0]  cfg_duty;
  logic        cfg_toggle;
  logic        frame_ok;
  logic        frame_err;
  logic [3:0]  err_count;

  spi_pwm_frame_rx dut (
    .rst        (rst),
    .spi_sclk   (spi_sclk),
    .spi_cs     (spi_cs),
    .spi_mosi   (spi_mosi),
    .spi_miso   (spi_miso),
    .cfg_div    (cfg_div),
    .cfg_duty   (cfg_duty),
    .cfg_toggle (cfg_toggle),
    .frame_ok   (frame_ok),
    .frame_err  (frame_err),
    .err_count  (err_count)
  );

  // clock / reset
  initial spi_sclk = 1'b0;
  always #5 spi_sclk = ~spi_sclk;

  int total = 0;
  int bad   = 0;
  int ok_n  = 0;
  int err_n = 0;
  logic [7:0] miso_b;

  always @(negedge spi_sclk) begin
    if (frame_ok === 1'b1)  ok_n++;
    if (frame_err === 1'b1) err_n++;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // driver tasks: inputs change on the falling edge, MISO sampled there too
  task automatic shift_bits(input logic [63:0] b, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge spi_sclk);
      spi_cs   = 1'b0;
      spi_mosi = b[i];
      #1;
      if (i < 8) miso_b[i] = spi_miso;
    end
  endtask

  task automatic end_frame();
    @(negedge spi_sclk);
    spi_cs   = 1'b1;
    spi_mosi = 1'b0;
    repeat (2) @(negedge spi_sclk);
    #1;
  endtask

  task automatic run_frame(input logic [63:0] b, input int n, output int d_ok, output int d_err);
    int o0, e0;
    o0 = ok_n;
    e0 = err_n;
    shift_bits(b, n);
    end_frame();
    d_ok  = ok_n - o0;
    d_err = err_n - e0;
  endtask

  typedef struct {
    logic [31:0] div;
    logic [7:0]  duty;
    logic [7:0]  chk;
    logic [31:0] exp_div;
    logic [7:0]  exp_duty;
    logic        exp_tog;
    logic [3:0]  exp_err;
    logic [7:0]  exp_miso;
    int          exp_ok;
    int          exp_ferr;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int d_ok, d_err;
    logic [63:0] fb;

    vecs[0] = '{32'h000003E8, 8'h80, 8'h6B, 32'd1000,      8'h80, 1'b1, 4'd0, 8'h00, 1, 0};
    vecs[1] = '{32'h000003E8, 8'h80, 8'h6A, 32'd1000,      8'h80, 1'b1, 4'd1, 8'h01, 0, 1};
    vecs[2] = '{32'h12345678, 8'h55, 8'h5D, 32'h12345678,  8'h55, 1'b0, 4'd1, 8'h12, 1, 0};
    vecs[3] = '{32'hFFFFFFFF, 8'h00, 8'h00, 32'hFFFFFFFF,  8'h00, 1'b1, 4'd1, 8'h11, 1, 0};
    vecs[4] = '{32'h00000001, 8'hFF, 8'hFF, 32'hFFFFFFFF,  8'h00, 1'b1, 4'd2, 8'h11, 0, 1};

    rst      = 1'b0;
    spi_cs   = 1'b1;
    spi_mosi = 1'b0;
    repeat (3) @(negedge spi_sclk);
    #1;
    check("rst_div",    cfg_div,    64'd17);
    check("rst_duty",   cfg_duty,   64'd0);
    check("rst_toggle", cfg_toggle, 64'd0);
    check("rst_errcnt", err_count,  64'd0);
    check("rst_miso",   spi_miso,   64'd0);
    check("rst_ok",     frame_ok,   64'd0);
    check("rst_err",    frame_err,  64'd0);
    @(negedge spi_sclk);
    rst = 1'b1;
    repeat (2) @(negedge spi_sclk);

    for (int v = 0; v < 5; v++) begin
      fb = {16'h0, vecs[v].chk, vecs[v].duty, vecs[v].div};
      run_frame(fb, 48, d_ok, d_err);
      check($sformatf("v%0d_div", v),    cfg_div,    vecs[v].exp_div);
      check($sformatf("v%0d_duty", v),   cfg_duty,   vecs[v].exp_duty);
      check($sformatf("v%0d_toggle", v), cfg_toggle, vecs[v].exp_tog);
      check($sformatf("v%0d_errcnt", v), err_count,  vecs[v].exp_err);
      check($sformatf("v%0d_miso", v),   miso_b,     vecs[v].exp_miso);
      check($sformatf("v%0d_okpulse", v),  d_ok,  vecs[v].exp_ok);
      check($sformatf("v%0d_errpulse", v), d_err, vecs[v].exp_ferr);
    end

    // abort after 20 bits
    run_frame(64'h000000000F0F0F, 20, d_ok, d_err);
    check("abort_okpulse",  d_ok,      64'd0);
    check("abort_errpulse", d_err,     64'd1);
    check("abort_errcnt",   err_count, 64'd3);
    check("abort_div",      cfg_div,   64'hFFFFFFFF);
    check("abort_duty",     cfg_duty,  64'h00);

    // valid frame with 5 extra bits; status reflects the abort
    run_frame({16'h001F, 8'h4A, 8'h40, 32'h0000000A}, 53, d_ok, d_err);
    check("ovr_miso",     miso_b,     64'h34);
    check("ovr_okpulse",  d_ok,       64'd1);
    check("ovr_errpulse", d_err,      64'd1);
    check("ovr_errcnt",   err_count,  64'd4);
    check("ovr_div",      cfg_div,    64'h0A);
    check("ovr_duty",     cfg_duty,   64'h40);
    check("ovr_toggle",   cfg_toggle, 64'd0);

    // saturation: 17 bad-checksum frames
    begin
      int tot_err;
      tot_err = 0;
      for (int k = 0; k < 17; k++) begin
        run_frame({16'h0, 8'h6A, 8'h80, 32'h000003E8}, 48, d_ok, d_err);
        tot_err += d_err;
      end
      check("sat_errpulses", tot_err,   64'd17);
      check("sat_errcnt",    err_count, 64'd15);
      check("sat_div",       cfg_div,   64'h0A);
    end

    // reset in the middle of a frame
    shift_bits({16'h0, 8'h6B, 8'h80, 32'h000003E8}, 10);
    @(negedge spi_sclk);
    rst = 1'b0;
    #1;
    check("mrst_div",    cfg_div,    64'd17);
    check("mrst_duty",   cfg_duty,   64'd0);
    check("mrst_errcnt", err_count,  64'd0);
    check("mrst_toggle", cfg_toggle, 64'd0);
    check("mrst_miso",   spi_miso,   64'd0);
    @(negedge spi_sclk);
    spi_cs = 1'b1;
    rst    = 1'b1;
    repeat (2) @(negedge spi_sclk);

    // status readback: valid frame, then the next frame reports ok
    run_frame({16'h0, 8'h6B, 8'h80, 32'h000003E8}, 48, d_ok, d_err);
    check("rb1_miso",   miso_b,     64'h00);
    check("rb1_div",    cfg_div,    64'd1000);
    check("rb1_toggle", cfg_toggle, 64'd1);
    run_frame({16'h0, 8'h6B, 8'h80, 32'h000003E8}, 48, d_ok, d_err);
    check("rb2_miso",   miso_b,     64'h01);
    check("rb2_toggle", cfg_toggle, 64'd0);
    check("rb2_okpulse", d_ok,      64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
